period_meter: RTL and testbench

Measures the period of a slow, divided clock or strobe in the fast system-clock domain. This is the receiving end of the clock-divider output: it synchronises the incoming slow signal, emits single-cycle rise/fall pulses, and reports the clk-cycle count between consecutive rising edges. It also flags loss of the signal when no rising edge arrives within a timeout. Used for self-checking the divided clocks and for deriving tick strobes in the vending-machine datapath.

---
 rtl/period_meter_pkg.sv | 15 +
 rtl/period_meter_if.sv | 23 ++
 rtl/period_meter_sync_edge.sv | 74 +++++++
 rtl/period_meter.sv | 118 +++++++++++
 tb/tb_period_meter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter: FSM state, counter width, loss timeout, glitch-filter length.
// Pure declarations; no latency or backpressure applies.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } pm_state_e;

    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 1000000;
    localparam int FILT_LEN    = 3;

endpackage

// File: rtl/period_meter_if.sv
// Signal bundle between a measured strobe source/consumer (master) and the period meter (slave).
// Plain wires only: no latency, no backpressure.
interface period_meter_if #(
    parameter int W = period_meter_pkg::DEF_W
);
    logic         sig_in;
    logic         rise_pulse;
    logic         fall_pulse;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         timeout;

    modport master (
        output sig_in,
        input  rise_pulse, fall_pulse, period, period_valid, locked, timeout
    );

    modport slave (
        input  sig_in,
        output rise_pulse, fall_pulse, period, period_valid, locked, timeout
    );
endinterface

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchroniser, optional 3-cycle glitch filter and combinational rise/fall detect of sig_in.
// rise/fall valid 2 clk after sig_in changes (4 with filter); no backpressure.
module period_meter_sync_edge
    import period_meter_pkg::*;
#(
    parameter bit FILT_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sig_s_q, sig_s_d;
    logic sig_d_q, sig_d_d;

    always_comb begin
        meta_d  = sig_in;
        sig_s_d = meta_q;
        sig_d_d = sig_s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sig_s_q <= 1'b0;
            sig_d_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sig_s_q <= sig_s_d;
            sig_d_q <= sig_d_d;
        end
    end

    generate
        if (FILT_EN) begin : g_filt
            logic [FILT_LEN-3:0] old_q, old_d;
            logic [FILT_LEN-1:0] win;
            logic                filt_q, filt_d;

            // Window of the last FILT_LEN synchronised samples, newest in bit 0.
            always_comb begin
                win    = {old_q, sig_d_q, sig_s_q};
                old_d  = win[FILT_LEN-2:1];
                filt_d = filt_q;
                if (&win) begin
                    filt_d = 1'b1;
                end else if (~|win) begin
                    filt_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    old_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    old_q  <= old_d;
                    filt_q <= filt_d;
                end
            end

            // Edge is flagged the cycle the new level is accepted, before filt_q catches up.
            assign rise = filt_d & ~filt_q;
            assign fall = ~filt_d & filt_q;
        end else begin : g_raw
            assign rise = sig_s_q & ~sig_d_q;
            assign fall = ~sig_s_q & sig_d_q;
        end
    endgenerate

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between rising edges of async sig_in, flags loss after TIMEOUT idle cycles; macro PERIOD_METER_GLITCH_FILTER_EN adds a 3-cycle glitch filter.
// Outputs registered, pulses 3 clk after sig_in edge (5 with filter); no backpressure.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    period_meter_if.slave pm
);

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

    logic rise, fall;

    period_meter_sync_edge #(.FILT_EN(FILT_EN)) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (pm.sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    pm_state_e    state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         pv_q, pv_d;
    logic         rp_q, rp_d;
    logic         fp_q, fp_d;
    logic         locked_q, locked_d;
    logic         to_q, to_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        rp_d     = rise;
        fp_d     = fall;
        locked_d = locked_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = W'(1);
                end
            end
            MEASURE: begin
                // A rise on the last counting cycle wins over the timeout.
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    locked_d = 1'b1;
                    cnt_d    = W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = LOST;
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            LOST: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = W'(1);
                    to_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            rp_q     <= 1'b0;
            fp_q     <= 1'b0;
            locked_q <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            rp_q     <= rp_d;
            fp_q     <= fp_d;
            locked_q <= locked_d;
            to_q     <= to_d;
        end
    end

    assign pm.rise_pulse   = rp_q;
    assign pm.fall_pulse   = fp_q;
    assign pm.period       = period_q;
    assign pm.period_valid = pv_q;
    assign pm.locked       = locked_q;
    assign pm.timeout      = to_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT=20: reset, steady period, timeout, boundary, recovery, glitch.
// Tick n = sig_in driven then clk edge n; outputs sampled 1ns after the edge.
module tb_period_meter;

    localparam int W  = 32;
    localparam int TO = 20;
`ifdef PERIOD_METER_GLITCH_FILTER_EN
    localparam int L       = 4;
    localparam int GLITCH_RISES = 0;
`else
    localparam int L       = 2;
    localparam int GLITCH_RISES = 1;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic to_prev = 1'b0;
    logic lk_prev = 1'b0;
    int   rise_q[$], fall_q[$], pv_q[$], per_q[$], to_rise_q[$], to_fall_q[$], lk_rise_q[$];
    int   t1, t3, t4, t5, t6;

    period_meter_if #(.W(W)) pm_if ();

    period_meter #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .pm  (pm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tk(input logic s);
        pm_if.sig_in = s;
        @(posedge clk);
        #1;
        cyc++;
        if (pm_if.rise_pulse) rise_q.push_back(cyc);
        if (pm_if.fall_pulse) fall_q.push_back(cyc);
        if (pm_if.period_valid) begin
            pv_q.push_back(cyc);
            per_q.push_back(int'(pm_if.period));
        end
        if (pm_if.timeout && !to_prev) to_rise_q.push_back(cyc);
        if (!pm_if.timeout && to_prev) to_fall_q.push_back(cyc);
        if (pm_if.locked && !lk_prev) lk_rise_q.push_back(cyc);
        to_prev = pm_if.timeout;
        lk_prev = pm_if.locked;
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) tk(s);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic clr();
        rise_q.delete(); fall_q.delete(); pv_q.delete(); per_q.delete();
        to_rise_q.delete(); to_fall_q.delete(); lk_rise_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        pm_if.sig_in = 1'b0;

        // Reset with sig_in toggling: every output stays 0.
        for (int i = 0; i < 3; i++) begin
            tk(i[0] ? 1'b0 : 1'b1);
            chk("rst_flags", int'({pm_if.rise_pulse, pm_if.fall_pulse, pm_if.period_valid,
                                   pm_if.locked, pm_if.timeout}), 0);
            chk("rst_period", int'(pm_if.period), 0);
        end
        rst = 1'b0;
        clr();

        // IDLE never times out and sees no edge.
        hold(1'b0, 30);
        chk("idle_rises", rise_q.size(), 0);
        chk("idle_timeout", int'(pm_if.timeout), 0);
        chk("idle_locked", int'(pm_if.locked), 0);

        // Steady 8-cycle period, then hold low into LOST.
        clr();
        t1 = cyc + 1;
        wave(4, 4, 4);
        hold(1'b0, 25);
        chk("p8_nrise", rise_q.size(), 4);
        chk("p8_nfall", fall_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("p8_rise_at", at(rise_q, i), t1 + L + 8 * i);
            chk("p8_fall_at", at(fall_q, i), t1 + 4 + L + 8 * i);
        end
        chk("p8_npv", pv_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("p8_pv_at", at(pv_q, i), t1 + 8 + L + 8 * i);
            chk("p8_period", at(per_q, i), 8);
        end
        chk("p8_lock_at", at(lk_rise_q, 0), t1 + 8 + L);
        // Last rise_pulse at t1+24+L; counter reaches TIMEOUT-1 and trips 19 edges later.
        chk("to_at", at(to_rise_q, 0), t1 + 24 + L + TO - 1);
        chk("to_level", int'(pm_if.timeout), 1);
        chk("to_locked", int'(pm_if.locked), 0);
        chk("to_period_kept", int'(pm_if.period), 8);

        // Boundary: rises exactly TIMEOUT-1 apart starting from LOST.
        clr();
        t3 = cyc + 1;
        wave(9, 10, 3);
        chk("b_to_clear_at", at(to_fall_q, 0), t3 + L);
        chk("b_no_timeout", to_rise_q.size(), 0);
        chk("b_npv", pv_q.size(), 2);
        chk("b_pv0_at", at(pv_q, 0), t3 + 19 + L);
        chk("b_period0", at(per_q, 0), 19);
        chk("b_period1", at(per_q, 1), 19);
        chk("b_locked", int'(pm_if.locked), 1);
        hold(1'b0, 30);
        chk("b_to_at", at(to_rise_q, 0), t3 + 38 + L + TO - 1);

        // Recovery from LOST with a 12-cycle period.
        clr();
        t4 = cyc + 1;
        wave(6, 6, 3);
        hold(1'b0, 6);
        chk("r_to_clear_at", at(to_fall_q, 0), t4 + L);
        chk("r_npv", pv_q.size(), 2);
        chk("r_pv0_at", at(pv_q, 0), t4 + 12 + L);
        chk("r_period0", at(per_q, 0), 12);
        chk("r_period1", at(per_q, 1), 12);
        chk("r_lock_at", at(lk_rise_q, 0), t4 + 12 + L);

        // Two-cycle high pulse: seen only without the filter.
        clr();
        t5 = cyc + 1;
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk("g2_nrise", rise_q.size(), GLITCH_RISES);
        chk("g2_rise_at", at(rise_q, 0), (GLITCH_RISES == 1) ? t5 + L : -1);

        // Three-cycle high level: always accepted, filter adds 2 cycles.
        clr();
        t6 = cyc + 1;
        hold(1'b1, 3);
        hold(1'b0, 10);
        chk("g3_nrise", rise_q.size(), 1);
        chk("g3_rise_at", at(rise_q, 0), t6 + L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
